mdr_unit: RTL
=============

MDR_UNIT -- requirements
Module: mdr_unit

Interface
REQ-001 Parameter ADDR_W, default 9: memory address width.
REQ-002 Parameter MAX_WAIT, default 15: wait-cycle limit before timeout (used only with MDR_TIMEOUT_EN).
REQ-003 clock  input  1  rising-edge system clock; the block uses one clock.
REQ-004 clear_n  input  1  asynchronous, active-low reset.
REQ-005 bus_in  input  32  value currently on the bus output.
REQ-006 mdr_load  input  1  load MDR from bus_in.
REQ-007 mar_in  input  32  MAR contents; the low ADDR_W bits are the address.
REQ-008 read_req  input  1  start a memory read into the MDR.
REQ-009 write_req  input  1  start a memory write from the MDR.
REQ-010 mem_rdata  input  32  memory read data.
REQ-011 mem_ready  input  1  memory completes the current access.
REQ-012 mdr_out  output  32  MDR contents; this drives the bus mdr_in source.
REQ-013 mem_addr  output  ADDR_W  registered access address.
REQ-014 mem_wdata  output  32  registered write data.
REQ-015 mem_rd  output  1  read strobe.
REQ-016 mem_wr  output  1  write strobe.
REQ-017 busy  output  1  high while in RD_WAIT or WR_WAIT.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 The FSM SHALL have four states: IDLE, RD_WAIT, WR_WAIT and DONE. All outputs SHALL be registered.
REQ-021 IDLE, on read_req: capture mem_addr=mar_in[ADDR_W-1:0], assert mem_rd, clear err, and go to RD_WAIT.
REQ-022 IDLE, on write_req without read_req: capture mem_addr, set mem_wdata=mdr_out, assert mem_wr, clear err, and go to WR_WAIT.
REQ-023 If read_req and write_req are both high, the read wins and the write is dropped.
REQ-024 IDLE, on mdr_load: mdr_out SHALL take bus_in at the next edge.
REQ-025 If mdr_load and write_req are high in the same cycle, mem_wdata SHALL take bus_in (forwarding).
REQ-026 If mdr_load and read_req are high in the same cycle, the MDR loads bus_in now and is overwritten when the read completes.
REQ-027 mdr_load, read_req and write_req SHALL be ignored outside IDLE.
REQ-028 RD_WAIT, when mem_ready is high: mdr_out=mem_rdata, mem_rd drops, and the FSM goes to DONE.
REQ-029 WR_WAIT, when mem_ready is high: mem_wr drops and the FSM goes to DONE.
REQ-030 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-031 Latency: with read_req accepted at edge N and mem_ready high in cycle N+1, mdr_out updates and done goes high at edge N+2.
REQ-032 mem_rd and mem_wr SHALL never be high together; each stays high continuously until completion or timeout.
REQ-033 mem_ready SHALL be ignored in IDLE and DONE.

Reset
REQ-034 clear_n low SHALL immediately force: state IDLE; mdr_out, mem_addr and mem_wdata to 0; mem_rd, mem_wr, busy, done and err to 0; and the wait counter to 0.
REQ-035 Reset during RD_WAIT or WR_WAIT SHALL abort the access with no done pulse.
REQ-036 After reset is released, the first rising edge SHALL operate normally.

Configuration
REQ-037 Macro MDR_TIMEOUT_EN, when defined: a wait counter runs from 0 in RD_WAIT/WR_WAIT. If MAX_WAIT cycles pass without mem_ready, the block drops the strobe, sets err, pulses done via DONE, and leaves mdr_out unchanged.
REQ-038 When MDR_TIMEOUT_EN is not defined: no counter exists, waits last indefinitely, and err SHALL be tied to 0.

Verification
REQ-039 Load, then write: bus_in=0xDEADBEEF with mdr_load; then mar_in=0x15 with write_req -> mem_wr high, mem_addr=0x015, mem_wdata=0xDEADBEEF, done one cycle after mem_ready.
REQ-040 Read with 3 wait cycles: mar_in=0x1FF, read_req; mem_ready in the 4th RD_WAIT cycle with mem_rdata=0x12345678 -> mdr_out=0x12345678, busy high for 4 cycles, done for 1 cycle.
REQ-041 Simultaneous events: read_req+write_req -> only mem_rd asserted. Then mdr_load(bus_in=0xA5A5A5A5)+write_req -> mem_wdata=0xA5A5A5A5.
REQ-042 Busy inputs ignored: during RD_WAIT, pulse mdr_load with bus_in=0x1 and write_req -> no mem_wr; after the read, mdr_out equals mem_rdata.
REQ-043 Timeout, with MDR_TIMEOUT_EN and MAX_WAIT=15: read with mem_ready held low -> mem_rd drops after 15 cycles, err=1, done pulses, mdr_out unchanged; the next read_req clears err.
REQ-044 Reset mid-read: clear_n low in RD_WAIT -> all outputs 0 at once and no done pulse; the next read_req completes normally.

Source files
------------

// File: rtl/mdr_unit.sv
// Memory data register with a read/write handshake FSM toward a simple ready-based memory.
// Optional macro MDR_TIMEOUT_EN adds a wait counter that aborts stalled accesses and sets err.
module mdr_unit #(
    parameter int ADDR_W   = 9,
    parameter int MAX_WAIT = 15
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic [31:0]       bus_in,
    input  logic              mdr_load,
    input  logic [31:0]       mar_in,
    input  logic              read_req,
    input  logic              write_req,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       mdr_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         mdr_q, mdr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Only the low ADDR_W bits of the MAR form the address.
    logic unused_mar;
    assign unused_mar = ^mar_in[31:ADDR_W];

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;

    // Timeout fires on the MAX_WAIT-th wait cycle without ready, so the strobe lasts MAX_WAIT cycles.
    assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));
`endif

    always_comb begin
        state_d = state_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MDR_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (mdr_load) mdr_d = bus_in;
                if (read_req) begin
                    addr_d  = mar_in[ADDR_W-1:0];
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RD_WAIT;
`ifdef MDR_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end else if (write_req) begin
                    addr_d  = mar_in[ADDR_W-1:0];
                    // Forward a same-cycle MDR load straight into the write data.
                    wdata_d = mdr_load ? bus_in : mdr_q;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = WR_WAIT;
`ifdef MDR_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            RD_WAIT: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    rd_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`ifdef MDR_TIMEOUT_EN
                else if (timeout) begin
                    rd_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            WR_WAIT: begin
                if (mem_ready) begin
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`ifdef MDR_TIMEOUT_EN
                else if (timeout) begin
                    wr_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            mdr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef MDR_TIMEOUT_EN
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mdr_out   = mdr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
